// File: rtl/quad_tick_window.sv
// quad_tick_window
// Quadrature encoder front end for the odometry path. Both raw wheel
// channels are synchronized, glitch-filtered and 4x decoded. Signed ticks
// are accumulated over a fixed window, and one saturated 8-bit count is
// published per window.
//
// Ports
//   CLK          system clock, rising edge
//   rst          asynchronous active-high reset
//   signalA/B    raw encoder channels, asynchronous to CLK
//   ticks        signed tick count of the last completed window
//   ticks_valid  one-cycle strobe, high in the cycle ticks updates
//   dir          direction of the last legal transition (1 = forward)
//   sat          published window's count saturated
//   err          published window saw an illegal (double) transition
module quad_tick_window #(
  parameter int unsigned WINDOW_CYCLES = 1200000,
  parameter int unsigned FILTER_LEN    = 4
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       signalA,
  input  logic       signalB,
  output logic [7:0] ticks,
  output logic       ticks_valid,
  output logic       dir,
  output logic       sat,
  output logic       err
);

  localparam int unsigned WCW = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WCW-1:0] WIN_LAST = WCW'(WINDOW_CYCLES - 1);
  localparam logic [3:0] FLT_LAST = 4'(FILTER_LEN - 1);

  // Channel pairs are packed as {A, B}.
  logic [1:0]      sync1_q, sync1_d;
  logic [1:0]      sync2_q, sync2_d;
  logic [1:0][3:0] flt_cnt_q, flt_cnt_d;
  logic [1:0]      ab_q, ab_d;
  logic [1:0]      prev_ab_q, prev_ab_d;

  logic [7:0]      acc_q, acc_d;
  logic            sat_flag_q, sat_flag_d;
  logic            err_flag_q, err_flag_d;
  logic [WCW-1:0]  win_cnt_q, win_cnt_d;

  logic [7:0]      ticks_q, ticks_d;
  logic            valid_q, valid_d;
  logic            dir_q, dir_d;
  logic            sat_q, sat_d;
  logic            err_q, err_d;

  logic [1:0]      idx_prev, idx_cur, idx_step;
  logic            step_fwd, step_rev, step_ill;
  logic [7:0]      acc_nxt;
  logic            sat_evt;
  logic            win_last;

  // Synchronizer and per-channel glitch filter. The filter counter only
  // runs while the synchronized sample disagrees with the accepted level;
  // any agreeing sample restarts it, so a level must persist for
  // FILTER_LEN consecutive samples before it is accepted.
  always_comb begin
    sync1_d   = {signalA, signalB};
    sync2_d   = sync1_q;
    ab_d      = ab_q;
    flt_cnt_d = flt_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == ab_q[i]) begin
        flt_cnt_d[i] = 4'd0;
      end else if (flt_cnt_q[i] == FLT_LAST) begin
        ab_d[i]      = sync2_q[i];
        flt_cnt_d[i] = 4'd0;
      end else begin
        flt_cnt_d[i] = flt_cnt_q[i] + 4'd1;
      end
    end
    prev_ab_d = ab_q;
  end

  // Map the forward cycle 00 -> 10 -> 11 -> 01 onto 0..3; the modular
  // index difference then gives +1 (forward), 3 (reverse) or 2 (both bits
  // changed, illegal).
  always_comb begin
    idx_prev = {prev_ab_q[0], prev_ab_q[1] ^ prev_ab_q[0]};
    idx_cur  = {ab_q[0], ab_q[1] ^ ab_q[0]};
    idx_step = idx_cur - idx_prev;
    step_fwd = (idx_step == 2'd1);
    step_rev = (idx_step == 2'd3);
    step_ill = (idx_step == 2'd2);
  end

  // Accumulator, window flags, window counter and published outputs.
  always_comb begin
    acc_nxt = acc_q;
    sat_evt = 1'b0;
    if (step_fwd) begin
      if (acc_q == 8'h7F) sat_evt = 1'b1;
      else                acc_nxt = acc_q + 8'd1;
    end else if (step_rev) begin
      if (acc_q == 8'h80) sat_evt = 1'b1;
      else                acc_nxt = acc_q - 8'd1;
    end

    win_last   = (win_cnt_q == WIN_LAST);
    win_cnt_d  = win_last ? '0 : win_cnt_q + WCW'(1);

    acc_d      = acc_nxt;
    sat_flag_d = sat_flag_q | sat_evt;
    err_flag_d = err_flag_q | step_ill;

    ticks_d    = ticks_q;
    sat_d      = sat_q;
    err_d      = err_q;
    valid_d    = win_last;
    dir_d      = dir_q;
    if (step_fwd)      dir_d = 1'b1;
    else if (step_rev) dir_d = 1'b0;

    // The terminal cycle's own increment and events close with this
    // window; the next window starts from a clean zero.
    if (win_last) begin
      ticks_d    = acc_nxt;
      sat_d      = sat_flag_d;
      err_d      = err_flag_d;
      acc_d      = 8'd0;
      sat_flag_d = 1'b0;
      err_flag_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      sync1_q    <= 2'b00;
      sync2_q    <= 2'b00;
      flt_cnt_q  <= '0;
      ab_q       <= 2'b00;
      prev_ab_q  <= 2'b00;
      acc_q      <= 8'd0;
      sat_flag_q <= 1'b0;
      err_flag_q <= 1'b0;
      win_cnt_q  <= '0;
      ticks_q    <= 8'd0;
      valid_q    <= 1'b0;
      dir_q      <= 1'b0;
      sat_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      flt_cnt_q  <= flt_cnt_d;
      ab_q       <= ab_d;
      prev_ab_q  <= prev_ab_d;
      acc_q      <= acc_d;
      sat_flag_q <= sat_flag_d;
      err_flag_q <= err_flag_d;
      win_cnt_q  <= win_cnt_d;
      ticks_q    <= ticks_d;
      valid_q    <= valid_d;
      dir_q      <= dir_d;
      sat_q      <= sat_d;
      err_q      <= err_d;
    end
  end

  assign ticks       = ticks_q;
  assign ticks_valid = valid_q;
  assign dir         = dir_q;
  assign sat         = sat_q;
  assign err         = err_q;

endmodule

// File: tb/tb_quad_tick_window.sv
// tb_quad_tick_window
// Directed bench for quad_tick_window. Two instances share clock, reset
// and encoder inputs: dut uses a 100-cycle window, dut_s a 2000-cycle
// window for the saturation scenario. Expected values are hand-computed.
module tb_quad_tick_window;

  logic       CLK;
  logic       rst;
  logic       signalA, signalB;
  logic [7:0] ticks, ticks_s;
  logic       tv, tv_s;
  logic       dir, dir_s;
  logic       sat, sat_s;
  logic       err, err_s;

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] ab;
  int cyc;

  quad_tick_window #(.WINDOW_CYCLES(100), .FILTER_LEN(4)) dut (
    .CLK(CLK), .rst(rst), .signalA(signalA), .signalB(signalB),
    .ticks(ticks), .ticks_valid(tv), .dir(dir), .sat(sat), .err(err)
  );

  quad_tick_window #(.WINDOW_CYCLES(2000), .FILTER_LEN(4)) dut_s (
    .CLK(CLK), .rst(rst), .signalA(signalA), .signalB(signalB),
    .ticks(ticks_s), .ticks_valid(tv_s), .dir(dir_s), .sat(sat_s), .err(err_s)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [1:0] v);
    case (v)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev(input logic [1:0] v);
    case (v)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic drive(input logic [1:0] v, input int hold);
    {signalA, signalB} = v;
    ab = v;
    repeat (hold) @(posedge CLK);
  endtask

  // Returns at #1 after the edge that raised the selected strobe.
  task automatic wait_strobe(input bit s, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 2200) begin
      @(posedge CLK);
      #1;
      n++;
      seen = s ? tv_s : tv;
    end
    if (!seen) chk("strobe_timeout", 16'd0, 16'd1);
  endtask

  initial begin
    signalA = 1'b0;
    signalB = 1'b0;
    ab = 2'b00;
    rst = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ticks", {8'd0, ticks}, 16'h00);
    chk("rst_flags", {12'd0, tv, dir, sat, err}, 16'h0);
    @(negedge CLK);
    rst = 1'b0;

    wait_strobe(0, cyc);
    chk("first_strobe_lat", 16'(cyc), 16'd100);
    chk("idle_ticks", {8'd0, ticks}, 16'h00);

    // Forward rotation: 10 steps
    for (int i = 0; i < 10; i++) drive(fwd(ab), 8);
    wait_strobe(0, cyc);
    chk("fwd_ticks", {8'd0, ticks}, 16'h0A);
    chk("fwd_dir", {15'd0, dir}, 16'd1);
    chk("fwd_sat_err", {14'd0, sat, err}, 16'd0);

    // Reverse rotation then empty window
    for (int i = 0; i < 6; i++) drive(rev(ab), 8);
    wait_strobe(0, cyc);
    chk("rev_ticks", {8'd0, ticks}, 16'hFA);
    chk("rev_dir", {15'd0, dir}, 16'd0);
    wait_strobe(0, cyc);
    chk("strobe_period", 16'(cyc), 16'd100);
    chk("clear_ticks", {8'd0, ticks}, 16'h00);

    // Glitch rejection: 3-cycle pulses on A only
    for (int i = 0; i < 3; i++) begin
      drive(2'b10, 3);
      drive(2'b00, 10);
    end
    wait_strobe(0, cyc);
    chk("glitch_ticks", {8'd0, ticks}, 16'h00);
    chk("glitch_dir", {15'd0, dir}, 16'd0);
    drive(2'b10, 1);
    wait_strobe(0, cyc);
    chk("a_rise_ticks", {8'd0, ticks}, 16'h01);
    chk("a_rise_dir", {15'd0, dir}, 16'd1);
    drive(2'b00, 1);
    wait_strobe(0, cyc);
    chk("a_fall_ticks", {8'd0, ticks}, 16'hFF);
    chk("a_fall_dir", {15'd0, dir}, 16'd0);

    // Illegal transitions after one forward step
    drive(2'b10, 10);
    drive(2'b01, 20);
    drive(2'b10, 20);
    wait_strobe(0, cyc);
    chk("ill_ticks", {8'd0, ticks}, 16'h01);
    chk("ill_err", {15'd0, err}, 16'd1);
    chk("ill_dir", {15'd0, dir}, 16'd1);
    chk("ill_sat", {15'd0, sat}, 16'd0);
    drive(2'b00, 1);
    wait_strobe(0, cyc);
    chk("post_ill_ticks", {8'd0, ticks}, 16'hFF);
    chk("post_ill_err", {15'd0, err}, 16'd0);

    // Edge accepted in the terminal cycle of the window
    repeat (93) @(posedge CLK);
    #1;
    drive(2'b10, 0);
    wait_strobe(0, cyc);
    chk("term_lat", 16'(cyc), 16'd7);
    chk("term_ticks", {8'd0, ticks}, 16'h01);
    wait_strobe(0, cyc);
    chk("term_next_ticks", {8'd0, ticks}, 16'h00);

    // Reset mid-window
    for (int i = 0; i < 5; i++) drive(fwd(ab), 8);
    wait_strobe(0, cyc);
    chk("pre_rst_ticks", {8'd0, ticks}, 16'h05);
    for (int i = 0; i < 5; i++) drive(fwd(ab), 8);
    repeat (10) @(posedge CLK);
    #1;
    rst = 1'b1;
    drive(2'b00, 0);
    #1;
    chk("midrst_ticks", {8'd0, ticks}, 16'h00);
    chk("midrst_flags", {12'd0, tv, dir, sat, err}, 16'h0);
    @(negedge CLK);
    rst = 1'b0;
    wait_strobe(0, cyc);
    chk("post_rst_lat", 16'(cyc), 16'd100);
    chk("post_rst_ticks", {8'd0, ticks}, 16'h00);

    // Saturation on the long-window instance
    wait_strobe(1, cyc);
    chk("s_first_lat", 16'(cyc), 16'd1900);
    for (int i = 0; i < 200; i++) drive(fwd(ab), 6);
    wait_strobe(1, cyc);
    chk("sat_ticks", {8'd0, ticks_s}, 16'h7F);
    chk("sat_flag", {15'd0, sat_s}, 16'd1);
    chk("sat_err", {15'd0, err_s}, 16'd0);
    chk("sat_dir", {15'd0, dir_s}, 16'd1);
    wait_strobe(1, cyc);
    chk("sat_next_ticks", {8'd0, ticks_s}, 16'h00);
    chk("sat_next_flag", {15'd0, sat_s}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
